// File: rtl/divider_pkg.sv
// Shared constants for the pipelined restoring divider.
// Optional feature macro: DIVIDER_DBZ_EN (divide-by-zero flag pipeline).
package divider_pkg;

    // Default operand width, shared with the multiplier datapath
    localparam int WIDTH_DEFAULT = 16;

    // Edges from operand sample to registered result: one stage per quotient bit
    function automatic int unsigned latency(input int unsigned width);
        return width;
    endfunction

    localparam int unsigned LATENCY = latency(WIDTH_DEFAULT);

endpackage

// File: rtl/divider_stage.sv
// One combinational restoring-division step: shift in a dividend bit,
// trial-subtract the divisor, keep or restore, emit one quotient bit.
module divider_stage
    import divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH:0]   rem_in,
    input  logic             dbit,
    input  logic [WIDTH-1:0] div,
    output logic [WIDTH:0]   rem_out,
    output logic             qbit
);

    logic [WIDTH+1:0] shifted;

    // Shift, compare against the divisor, select difference or restored value
    always_comb begin
        shifted = {rem_in, dbit};
        qbit    = (shifted >= {2'b00, div});
        rem_out = qbit ? (WIDTH+1)'(shifted - {2'b00, div}) : shifted[WIDTH:0];
    end

endmodule

// File: rtl/divider_pipelined.sv
// Fully pipelined unsigned restoring divider: stage 0 registers the
// operands, stages 1..WIDTH each resolve one quotient bit MSB first.
// Optional feature macro: DIVIDER_DBZ_EN adds a piped b==0 flag on dbz.
module divider_pipelined
    import divider_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ce,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             valid_out,
    output logic [WIDTH-1:0] q,
`ifdef DIVIDER_DBZ_EN
    output logic             dbz,
`endif
    output logic [WIDTH-1:0] r
);

    // Stage 0 (input register)
    logic [WIDTH-1:0] a0_q, b0_q;
    logic             v0_q;

    // Stages 1..WIDTH pipeline registers; dividend and divisor are not
    // needed after the last stage so their arrays stop at WIDTH-1
    logic [WIDTH:0]   rem_q [1:WIDTH];
    logic [WIDTH-1:0] quo_q [1:WIDTH];
    logic             val_q [1:WIDTH];
    logic [WIDTH-1:0] dvd_q [1:WIDTH-1];
    logic [WIDTH-1:0] div_q [1:WIDTH-1];

    // Per-stage inputs (previous register) and combinational results
    logic [WIDTH:0]   src_rem [1:WIDTH];
    logic [WIDTH-1:0] src_quo [1:WIDTH];
    logic [WIDTH-1:0] src_dvd [1:WIDTH];
    logic [WIDTH-1:0] src_div [1:WIDTH];
    logic             src_val [1:WIDTH];
    logic [WIDTH:0]   rem_nxt [1:WIDTH];
    logic [WIDTH-1:0] quo_nxt [1:WIDTH];
    logic             qbit    [1:WIDTH];

`ifdef DIVIDER_DBZ_EN
    logic z0_q;
    logic dbz_q   [1:WIDTH];
    logic src_dbz [1:WIDTH];
`endif

    // Input register: capture operands and valid on enabled edges
    always_ff @(posedge clk) begin
        if (rst) begin
            a0_q <= '0;
            b0_q <= '0;
            v0_q <= 1'b0;
        end else if (ce) begin
            a0_q <= a;
            b0_q <= b;
            v0_q <= valid_in;
        end
    end

`ifdef DIVIDER_DBZ_EN
    // Input register for the divide-by-zero flag
    always_ff @(posedge clk) begin
        if (rst)
            z0_q <= 1'b0;
        else if (ce)
            z0_q <= (b == '0);
    end
`endif

    for (genvar j = 1; j <= WIDTH; j++) begin : g_stage
        if (j == 1) begin : g_first
            assign src_rem[j] = '0;
            assign src_quo[j] = '0;
            assign src_dvd[j] = a0_q;
            assign src_div[j] = b0_q;
            assign src_val[j] = v0_q;
`ifdef DIVIDER_DBZ_EN
            assign src_dbz[j] = z0_q;
`endif
        end else begin : g_next
            assign src_rem[j] = rem_q[j-1];
            assign src_quo[j] = quo_q[j-1];
            assign src_dvd[j] = dvd_q[j-1];
            assign src_div[j] = div_q[j-1];
            assign src_val[j] = val_q[j-1];
`ifdef DIVIDER_DBZ_EN
            assign src_dbz[j] = dbz_q[j-1];
`endif
        end

        divider_stage #(.WIDTH(WIDTH)) u_stage (
            .rem_in  (src_rem[j]),
            .dbit    (src_dvd[j][WIDTH-j]),
            .div     (src_div[j]),
            .rem_out (rem_nxt[j]),
            .qbit    (qbit[j])
        );

        // Earlier stages only set higher bits, so OR-ing places bit WIDTH-j
        assign quo_nxt[j] = src_quo[j] | (WIDTH'(qbit[j]) << (WIDTH - j));

        // Stage register: remainder, quotient and valid advance on enabled edges
        always_ff @(posedge clk) begin
            if (rst) begin
                rem_q[j] <= '0;
                quo_q[j] <= '0;
                val_q[j] <= 1'b0;
            end else if (ce) begin
                rem_q[j] <= rem_nxt[j];
                quo_q[j] <= quo_nxt[j];
                val_q[j] <= src_val[j];
            end
        end

        if (j < WIDTH) begin : g_carry
            // Carry dividend and divisor forward for the remaining stages
            always_ff @(posedge clk) begin
                if (rst) begin
                    dvd_q[j] <= '0;
                    div_q[j] <= '0;
                end else if (ce) begin
                    dvd_q[j] <= src_dvd[j];
                    div_q[j] <= src_div[j];
                end
            end
        end

`ifdef DIVIDER_DBZ_EN
        // Divide-by-zero flag travels with its operand pair
        always_ff @(posedge clk) begin
            if (rst)
                dbz_q[j] <= 1'b0;
            else if (ce)
                dbz_q[j] <= src_dbz[j];
        end
`endif
    end

    assign valid_out = val_q[WIDTH];
    assign q         = quo_q[WIDTH];
    assign r         = rem_q[WIDTH][WIDTH-1:0];
`ifdef DIVIDER_DBZ_EN
    assign dbz       = dbz_q[WIDTH];
`endif

endmodule

// File: tb/tb_divider_pipelined.sv
// Self-checking bench for divider_pipelined: a delay-line model of the
// results (plain / and %) compared every cycle, plus directed literal checks.
// Honours DIVIDER_DBZ_EN for the dbz port.
module tb_divider_pipelined;
    import divider_pkg::*;

    localparam int W = WIDTH_DEFAULT;
    localparam int L = LATENCY;

    logic         clk = 1'b0;
    logic         rst, ce, valid_in;
    logic [W-1:0] a, b, q, r;
    logic         valid_out;
`ifdef DIVIDER_DBZ_EN
    logic         dbz;
`endif

    int checks = 0;
    int fails  = 0;
    bit cmp_en = 1'b0;

    always #5 clk = ~clk;

    divider_pipelined #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .valid_in  (valid_in),
        .a         (a),
        .b         (b),
        .valid_out (valid_out),
        .q         (q),
`ifdef DIVIDER_DBZ_EN
        .dbz       (dbz),
`endif
        .r         (r)
    );

    // Model: index 0 = just sampled, index L = visible on the outputs
    logic         mv [0:L];
    logic [W-1:0] mq [0:L];
    logic [W-1:0] mr [0:L];
    logic         mz [0:L];

    task automatic model_clear();
        for (int i = 0; i <= L; i++) begin
            mv[i] = 1'b0; mq[i] = '0; mr[i] = '0; mz[i] = 1'b0;
        end
    endtask

    task automatic model_push(input logic v, input logic [W-1:0] aa, input logic [W-1:0] bb);
        for (int i = L; i >= 1; i--) begin
            mv[i] = mv[i-1]; mq[i] = mq[i-1]; mr[i] = mr[i-1]; mz[i] = mz[i-1];
        end
        mv[0] = v;
        mz[0] = (bb == '0);
        mq[0] = (bb == '0) ? '1 : aa / bb;
        mr[0] = (bb == '0) ? aa : aa % bb;
    endtask

    // One clock: drive inputs, take the edge, advance the model, settle 1 time unit
    task automatic tick(input logic r_, input logic c_, input logic v_,
                        input logic [W-1:0] a_, input logic [W-1:0] b_);
        rst = r_; ce = c_; valid_in = v_; a = a_; b = b_;
        @(posedge clk);
        if (r_)      model_clear();
        else if (c_) model_push(v_, a_, b_);
        #1;
    endtask

    task automatic idle(input logic c_);
        tick(1'b0, c_, 1'b0, '0, '0);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Continuous compare against the model on the falling edge
    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if (valid_out !== mv[L]) begin
                fails++;
                $display("FAIL stream_valid @%0t: got %b expected %b", $time, valid_out, mv[L]);
            end else if (mv[L] && (q !== mq[L] || r !== mr[L])) begin
                fails++;
                $display("FAIL stream_data @%0t: got q=%0h r=%0h expected q=%0h r=%0h",
                         $time, q, r, mq[L], mr[L]);
            end
`ifdef DIVIDER_DBZ_EN
            else if (mv[L] && dbz !== mz[L]) begin
                fails++;
                $display("FAIL stream_dbz @%0t: got %b expected %b", $time, dbz, mz[L]);
            end
`endif
        end
    end

    logic [W-1:0] sa [0:19];
    logic [W-1:0] sb [0:19];
    int           vcount;

    initial begin
        model_clear();
        rst = 1'b1; ce = 1'b0; valid_in = 1'b0; a = '0; b = '0;

        // Reset state
        tick(1'b1, 1'b1, 1'b0, '0, '0);
        tick(1'b1, 1'b1, 1'b0, '0, '0);
        chk("reset_valid", 32'(valid_out), 0);
        chk("reset_q", 32'(q), 0);
        chk("reset_r", 32'(r), 0);
`ifdef DIVIDER_DBZ_EN
        chk("reset_dbz", 32'(dbz), 0);
`endif
        cmp_en = 1'b1;

        // Single operation 100/7
        tick(1'b0, 1'b1, 1'b1, 16'd100, 16'd7);
        for (int i = 1; i <= L + 1; i++) begin
            idle(1'b1);
            if (i == L - 1) chk("single_early", 32'(valid_out), 0);
            if (i == L) begin
                chk("single_valid", 32'(valid_out), 1);
                chk("single_q", 32'(q), 14);
                chk("single_r", 32'(r), 2);
            end
            if (i == L + 1) chk("single_after", 32'(valid_out), 0);
        end

        // 20 back-to-back pairs with boundary cases first
        sa[0] = 16'hFFFF; sb[0] = 16'd1;
        sa[1] = 16'd5;    sb[1] = 16'hFFFF;
        sa[2] = 16'd0;    sb[2] = 16'd3;
        sa[3] = 16'h8000; sb[3] = 16'h8000;
        for (int i = 4; i < 20; i++) begin
            sa[i] = W'($urandom);
            sb[i] = W'($urandom_range(1, 300));
        end
        vcount = 0;
        for (int i = 0; i < 20 + L + 2; i++) begin
            if (i < 20) tick(1'b0, 1'b1, 1'b1, sa[i], sb[i]);
            else        idle(1'b1);
            if (valid_out) vcount++;
            if (i == L)     begin chk("b2b_ffff_q", 32'(q), 32'hFFFF); chk("b2b_ffff_r", 32'(r), 0); end
            if (i == L + 1) begin chk("b2b_small_q", 32'(q), 0);       chk("b2b_small_r", 32'(r), 5); end
            if (i == L + 2) begin chk("b2b_zero_q", 32'(q), 0);        chk("b2b_zero_r", 32'(r), 0); end
            if (i == L + 3) begin chk("b2b_equal_q", 32'(q), 1);       chk("b2b_equal_r", 32'(r), 0); end
        end
        chk("b2b_count", 32'(vcount), 20);

        // Divide by zero followed by a normal pair
        tick(1'b0, 1'b1, 1'b1, 16'd1234, 16'd0);
        tick(1'b0, 1'b1, 1'b1, 16'd9, 16'd3);
        for (int i = 2; i <= L + 1; i++) begin
            idle(1'b1);
            if (i == L) begin
                chk("dbz_q", 32'(q), 32'hFFFF);
                chk("dbz_r", 32'(r), 1234);
`ifdef DIVIDER_DBZ_EN
                chk("dbz_flag", 32'(dbz), 1);
`endif
            end
            if (i == L + 1) begin
                chk("after_dbz_q", 32'(q), 3);
                chk("after_dbz_r", 32'(r), 0);
`ifdef DIVIDER_DBZ_EN
                chk("after_dbz_flag", 32'(dbz), 0);
`endif
            end
        end

        // Stall mid-flight for 3 cycles, then stall again with the result on the outputs;
        // operands driven during stalls must be ignored
        tick(1'b0, 1'b1, 1'b1, 16'd50, 16'd6);
        for (int i = 1; i <= L + 5; i++) begin
            if (i >= 5 && i <= 7)        tick(1'b0, 1'b0, 1'b1, 16'd999, 16'd1);
            else if (i >= L + 4)         tick(1'b0, 1'b0, 1'b1, 16'd777, 16'd2);
            else                         idle(1'b1);
            if (i == L)     chk("stall_nominal", 32'(valid_out), 0);
            if (i == L + 2) chk("stall_early", 32'(valid_out), 0);
            if (i >= L + 3) begin
                chk("stall_valid", 32'(valid_out), 1);
                chk("stall_q", 32'(q), 8);
                chk("stall_r", 32'(r), 2);
            end
        end
        idle(1'b1);

        // Reset with 4 pairs in flight (ce low to show reset wins), then one clean pair
        tick(1'b0, 1'b1, 1'b1, 16'd1000, 16'd3);
        tick(1'b0, 1'b1, 1'b1, 16'd2000, 16'd7);
        tick(1'b0, 1'b1, 1'b1, 16'd3000, 16'd11);
        tick(1'b0, 1'b1, 1'b1, 16'd4000, 16'd13);
        idle(1'b1);
        idle(1'b1);
        tick(1'b1, 1'b0, 1'b0, '0, '0);
        chk("rst_flight_valid", 32'(valid_out), 0);
        chk("rst_flight_q", 32'(q), 0);
        chk("rst_flight_r", 32'(r), 0);
        vcount = 0;
        tick(1'b0, 1'b1, 1'b1, 16'd77, 16'd5);
        for (int i = 1; i <= L + 4; i++) begin
            idle(1'b1);
            if (valid_out) vcount++;
            if (i == L) begin
                chk("post_rst_q", 32'(q), 15);
                chk("post_rst_r", 32'(r), 2);
            end
        end
        chk("post_rst_count", 32'(vcount), 1);

        // Randomised traffic with random ce and valid_in
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] ra, rb;
            ra = W'($urandom);
            case ($urandom_range(0, 7))
                0:       rb = '0;
                1, 2:    rb = W'($urandom_range(1, 15));
                default: rb = W'($urandom);
            endcase
            tick(1'b0, ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), ra, rb);
        end
        for (int i = 0; i < L + 4; i++) idle(1'b1);

        cmp_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
